// File: rtl/lbm_pkg.sv
// Shared D2Q9 lattice constants and the moment_calc FSM state type.
package lbm_pkg;

  localparam int Q_DIRS            = 9;
  localparam int FRAC_BITS_DEFAULT = 16;

  localparam int CX [Q_DIRS] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
  localparam int CY [Q_DIRS] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SUM,
    DIV,
    WRITE,
    DONE
  } mc_state_t;

endpackage

// File: rtl/seq_divider.sv
// Signed restoring divider: magnitudes, one quotient bit per cycle, truncation
// toward zero, result saturated to the DATA_WIDTH signed range.
module seq_divider #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            start,
  input  logic [DATA_WIDTH+FRAC_BITS-1:0] dividend,
  input  logic [DATA_WIDTH-1:0]           divisor,
  output logic [DATA_WIDTH-1:0]           quotient,
  output logic                            done
);

  localparam int NW = DATA_WIDTH + FRAC_BITS;
  localparam int CW = $clog2(NW);
  localparam logic [NW-1:0] POS_MAX = {{(FRAC_BITS+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [NW-1:0] NEG_MAG = POS_MAX + 1'b1;

  logic [NW-1:0]         quo_reg;
  logic [DATA_WIDTH-1:0] rem_reg;
  logic [DATA_WIDTH-1:0] dsr_reg;
  logic [CW-1:0]         cnt_reg;
  logic                  run_reg;
  logic                  zero_reg;
  logic                  neg_reg;

  logic [NW-1:0]         dvd_mag;
  logic [DATA_WIDTH-1:0] dsr_mag;
  logic [DATA_WIDTH:0]   rem_shift;
  logic [DATA_WIDTH:0]   diff;
  logic                  qbit;

  assign dvd_mag   = dividend[NW-1] ? (~dividend + 1'b1) : dividend;
  assign dsr_mag   = divisor[DATA_WIDTH-1] ? (~divisor + 1'b1) : divisor;
  // quo_reg shifts the dividend out at the top while quotient bits enter at the bottom
  assign rem_shift = {rem_reg, quo_reg[NW-1]};
  assign diff      = rem_shift - {1'b0, dsr_reg};
  assign qbit      = ~diff[DATA_WIDTH];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      quo_reg  <= '0;
      rem_reg  <= '0;
      dsr_reg  <= '0;
      cnt_reg  <= '0;
      run_reg  <= 1'b0;
      zero_reg <= 1'b0;
      neg_reg  <= 1'b0;
    end else if (start) begin
      rem_reg <= '0;
      dsr_reg <= dsr_mag;
      cnt_reg <= '0;
      if (divisor == '0) begin
        quo_reg  <= '0;
        neg_reg  <= 1'b0;
        run_reg  <= 1'b0;
        zero_reg <= 1'b1;
      end else begin
        quo_reg  <= dvd_mag;
        neg_reg  <= dividend[NW-1] ^ divisor[DATA_WIDTH-1];
        run_reg  <= 1'b1;
        zero_reg <= 1'b0;
      end
    end else begin
      zero_reg <= 1'b0;
      if (run_reg) begin
        quo_reg <= {quo_reg[NW-2:0], qbit};
        rem_reg <= qbit ? diff[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
        cnt_reg <= cnt_reg + 1'b1;
        if (cnt_reg == CW'(NW-1)) run_reg <= 1'b0;
      end
    end
  end

  assign done = (run_reg && (cnt_reg == CW'(NW-1))) || zero_reg;

  always_comb begin
    quotient = quo_reg[DATA_WIDTH-1:0];
    if (!neg_reg) begin
      if (quo_reg > POS_MAX) quotient = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      if (quo_reg > NEG_MAG) quotient = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else                   quotient = ~quo_reg[DATA_WIDTH-1:0] + 1'b1;
    end
  end

endmodule

// File: rtl/moment_calc.sv
// Sweeps the fin RAM cell by cell, forms the D2Q9 density and momentum and
// writes density plus the two velocity components (momentum / density).
module moment_calc
  import lbm_pkg::*;
#(
  parameter int GRID_DIM      = 16*16,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = $clog2(GRID_DIM),
  parameter int DATA_WIDTH_F  = 9*DATA_WIDTH,
  parameter int FRAC_BITS     = FRAC_BITS_DEFAULT
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] fin_addr,
  input  logic [DATA_WIDTH_F-1:0]  fin_data,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic                     WE_p_mem,
  output logic                     WE_ux_mem,
  output logic                     WE_uy_mem,
  output logic [DATA_WIDTH-1:0]    p_data,
  output logic [DATA_WIDTH-1:0]    ux_data,
  output logic [DATA_WIDTH-1:0]    uy_data
);

  localparam int ACC_W = DATA_WIDTH + 4;

  mc_state_t state_reg, state_next;
  logic [ADDRESS_WIDTH-1:0] idx_reg, idx_next;
  logic [ADDRESS_WIDTH-1:0] fin_addr_reg;
  logic [DATA_WIDTH-1:0]    rho_reg;

  logic signed [ACC_W-1:0] lane_ext [Q_DIRS];
  logic signed [ACC_W-1:0] rho_acc, jx_acc, jy_acc;
  logic [DATA_WIDTH-1:0]   rho_sum, jx_sum, jy_sum;
  logic [DATA_WIDTH-1:0]   ux_q, uy_q;
  logic                    ux_done, uy_done;
  logic                    div_start;
  logic                    we;
  logic                    unused_hi;

  for (genvar gi = 0; gi < Q_DIRS; gi++) begin : g_lane
    assign lane_ext[gi] = {{(ACC_W-DATA_WIDTH){fin_data[(gi+1)*DATA_WIDTH-1]}},
                           fin_data[(gi+1)*DATA_WIDTH-1 -: DATA_WIDTH]};
  end

  always_comb begin
    rho_acc = '0;
    jx_acc  = '0;
    jy_acc  = '0;
    for (int i = 0; i < Q_DIRS; i++) begin
      rho_acc = rho_acc + lane_ext[i];
      if (CX[i] > 0)      jx_acc = jx_acc + lane_ext[i];
      else if (CX[i] < 0) jx_acc = jx_acc - lane_ext[i];
      if (CY[i] > 0)      jy_acc = jy_acc + lane_ext[i];
      else if (CY[i] < 0) jy_acc = jy_acc - lane_ext[i];
    end
  end

  // Wider accumulation, then two's-complement wrap back to the word width
  assign rho_sum   = rho_acc[DATA_WIDTH-1:0];
  assign jx_sum    = jx_acc[DATA_WIDTH-1:0];
  assign jy_sum    = jy_acc[DATA_WIDTH-1:0];
  assign unused_hi = ^{rho_acc[ACC_W-1:DATA_WIDTH], jx_acc[ACC_W-1:DATA_WIDTH],
                       jy_acc[ACC_W-1:DATA_WIDTH]};

  // jx/jy are latched inside the dividers' operand registers on the SUM edge
  assign div_start = (state_reg == SUM);

  seq_divider #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_div_ux (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (div_start),
    .dividend ({jx_sum, {FRAC_BITS{1'b0}}}),
    .divisor  (rho_sum),
    .quotient (ux_q),
    .done     (ux_done)
  );

  seq_divider #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_div_uy (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (div_start),
    .dividend ({jy_sum, {FRAC_BITS{1'b0}}}),
    .divisor  (rho_sum),
    .quotient (uy_q),
    .done     (uy_done)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      fin_addr_reg <= '0;
      rho_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      fin_addr_reg <= fin_addr;
      if (state_reg == SUM) rho_reg <= rho_sum;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: if (start) begin
        state_next = READ;
        idx_next   = '0;
      end
      READ:  state_next = SUM;
      SUM:   state_next = DIV;
      DIV:   if (ux_done && uy_done) state_next = WRITE;
      WRITE: begin
        if (idx_reg == ADDRESS_WIDTH'(GRID_DIM-1)) begin
          state_next = DONE;
        end else begin
          state_next = READ;
          idx_next   = idx_reg + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign we        = (state_reg == WRITE);
  assign WE_p_mem  = we;
  assign WE_ux_mem = we;
  assign WE_uy_mem = we;
  assign wr_addr   = idx_reg;
  assign p_data    = we ? rho_reg : '0;
  assign ux_data   = we ? ux_q    : '0;
  assign uy_data   = we ? uy_q    : '0;
  assign fin_addr  = (state_reg == READ) ? idx_reg : fin_addr_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_moment_calc.sv
// Directed bench for moment_calc: table of per-cell vectors plus hand-written
// sequences for uniform, all-zero, held-start and mid-sweep reset sweeps.
module tb_moment_calc;

  localparam int GRID = 256;
  localparam int DW   = 32;
  localparam int AW   = 8;
  localparam int FW   = 9*DW;
  localparam int PER  = 51;
  localparam int LOGN = 600;

  logic          Clk;
  logic          Reset;
  logic          start;
  logic          busy, done;
  logic [AW-1:0] fin_addr, wr_addr;
  logic [FW-1:0] fin_data;
  logic          WE_p_mem, WE_ux_mem, WE_uy_mem;
  logic [DW-1:0] p_data, ux_data, uy_data;

  moment_calc dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .fin_addr  (fin_addr),
    .fin_data  (fin_data),
    .wr_addr   (wr_addr),
    .WE_p_mem  (WE_p_mem),
    .WE_ux_mem (WE_ux_mem),
    .WE_uy_mem (WE_uy_mem),
    .p_data    (p_data),
    .ux_data   (ux_data),
    .uy_data   (uy_data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [FW-1:0] fin_mem [GRID];
  always @(posedge Clk) fin_data <= fin_mem[fin_addr];

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // write log and event counters filled by the monitor
  logic [AW-1:0] log_addr [LOGN];
  logic [DW-1:0] log_p [LOGN], log_ux [LOGN], log_uy [LOGN];
  int            log_cyc [LOGN];
  int wr_n = 0, done_cnt = 0, done_cyc = 0, first_busy = -1, x_bad = 0, we_bad = 0;
  logic busy_prev = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] exp_p [GRID], exp_ux [GRID], exp_uy [GRID];

  typedef struct {
    int          addr;
    int          la;
    logic [31:0] va;
    int          lb;
    logic [31:0] vb;
    logic [31:0] p;
    logic [31:0] ux;
    logic [31:0] uy;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    forever begin
      @(negedge Clk);
      if (Reset) begin
        if ($isunknown({busy, done, WE_p_mem, WE_ux_mem, WE_uy_mem, fin_addr, wr_addr,
                        p_data, ux_data, uy_data})) x_bad++;
        if (WE_p_mem || WE_ux_mem || WE_uy_mem) begin
          if (!(WE_p_mem && WE_ux_mem && WE_uy_mem)) we_bad++;
          if (wr_n < LOGN) begin
            log_addr[wr_n] = wr_addr;
            log_p[wr_n]    = p_data;
            log_ux[wr_n]   = ux_data;
            log_uy[wr_n]   = uy_data;
            log_cyc[wr_n]  = cyc;
          end
          wr_n++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (busy && !busy_prev && first_busy < 0) first_busy = cyc;
      end
      busy_prev = busy;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] pack_lanes(input int la, input logic [31:0] va,
                                               input int lb, input logic [31:0] vb);
    logic [FW-1:0] w;
    w = '0;
    if (la >= 0) w[la*DW +: DW] = va;
    if (lb >= 0) w[lb*DW +: DW] = vb;
    return w;
  endfunction

  function automatic int exp_per(input int k);
    return (exp_p[k] != 0) ? PER : 4;
  endfunction

  task automatic clear_log();
    wr_n = 0; done_cnt = 0; first_busy = -1; x_bad = 0; we_bad = 0;
  endtask

  task automatic fill_mem(input logic [FW-1:0] w, input logic [31:0] p,
                          input logic [31:0] ux, input logic [31:0] uy);
    for (int k = 0; k < GRID; k++) begin
      fin_mem[k] = w;
      exp_p[k] = p; exp_ux[k] = ux; exp_uy[k] = uy;
    end
  endtask

  task automatic pulse_start();
    @(negedge Clk) start = 1'b1;
    @(negedge Clk) start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int base;
    int k;
    base = done_cnt;
    k = 0;
    while (done_cnt == base && k < budget) begin
      @(negedge Clk);
      #1;
      k++;
    end
    chk(name, 32'(done_cnt != base), 32'd1);
  endtask

  task automatic verify_sweep(input string tag);
    int addr_bad, data_bad, per_bad, n;
    addr_bad = 0; data_bad = 0; per_bad = 0;
    n = (wr_n < GRID) ? wr_n : GRID;
    chk({tag, "_writes"}, 32'(wr_n), 32'(GRID));
    for (int k = 0; k < n; k++) begin
      if (log_addr[k] !== AW'(k)) addr_bad++;
      if (log_p[k] !== exp_p[k] || log_ux[k] !== exp_ux[k] || log_uy[k] !== exp_uy[k]) data_bad++;
      if (k > 0 && (log_cyc[k] - log_cyc[k-1]) != exp_per(k)) per_bad++;
    end
    chk({tag, "_addr_order"}, 32'(addr_bad), 32'd0);
    chk({tag, "_data"}, 32'(data_bad), 32'd0);
    chk({tag, "_period"}, 32'(per_bad), 32'd0);
    chk({tag, "_first_latency"}, 32'(log_cyc[0] - first_busy), 32'(exp_per(0) - 1));
    chk({tag, "_we_together"}, 32'(we_bad), 32'd0);
    chk({tag, "_no_x"}, 32'(x_bad), 32'd0);
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    $display("sweep %s: writes=%0d addr_bad=%0d data_bad=%0d per_bad=%0d done=%0d",
             tag, wr_n, addr_bad, data_bad, per_bad, done_cnt);
  endtask

  initial begin
    int k, hits;
    logic [FW-1:0] w;

    vecs[0]  = '{5,   1, 32'h00010000, -1, 32'h0,        32'h00010000, 32'h00010000, 32'h00000000};
    vecs[1]  = '{7,   3, 32'h00010000,  2, 32'h00010000, 32'h00020000, 32'hFFFF8000, 32'h00008000};
    vecs[2]  = '{12,  0, 32'h00030000,  5, 32'h00010000, 32'h00040000, 32'h00004000, 32'h00004000};
    vecs[3]  = '{20,  0, 32'hFFFF0001,  1, 32'h00010000, 32'h00000001, 32'h7FFFFFFF, 32'h00000000};
    vecs[4]  = '{21,  0, 32'hFFFF0001,  3, 32'h00010000, 32'h00000001, 32'h80000000, 32'h00000000};
    vecs[5]  = '{22,  0, 32'hFFFF8001,  1, 32'h00008000, 32'h00000001, 32'h7FFFFFFF, 32'h00000000};
    vecs[6]  = '{23,  0, 32'hFFFF8001,  3, 32'h00008000, 32'h00000001, 32'h80000000, 32'h00000000};
    vecs[7]  = '{30,  0, 32'hFFFE0000,  1, 32'h00010000, 32'hFFFF0000, 32'hFFFF0000, 32'h00000000};
    vecs[8]  = '{31,  0, 32'h00000002,  1, 32'h00000001, 32'h00000003, 32'h00005555, 32'h00000000};
    vecs[9]  = '{32,  0, 32'h00000002,  3, 32'h00000001, 32'h00000003, 32'hFFFFAAAB, 32'h00000000};
    vecs[10] = '{40,  0, 32'h7FFFFFFF,  2, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'h00000000, 32'h80000000};
    vecs[11] = '{50,  6, 32'h00010000, -1, 32'h0,        32'h00010000, 32'hFFFF0000, 32'h00010000};
    vecs[12] = '{255, 8, 32'h00010000, -1, 32'h0,        32'h00010000, 32'h00010000, 32'hFFFF0000};

    start = 1'b0;
    Reset = 1'b1;
    fill_mem('0, 32'h0, 32'h0, 32'h0);

    // asynchronous reset with no clock edge in between
    #2 Reset = 1'b0;
    #1;
    chk("reset_busy_done", {30'd0, busy, done}, 32'd0);
    chk("reset_we", {29'd0, WE_p_mem, WE_ux_mem, WE_uy_mem}, 32'd0);
    chk("reset_addrs", {16'd0, fin_addr, wr_addr}, 32'd0);
    chk("reset_data", p_data | ux_data | uy_data, 32'd0);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);

    // uniform equilibrium weights, sum = 1.0
    w = '0;
    w[0*DW +: DW] = 32'h000071C8;
    for (int i = 1; i <= 4; i++) w[i*DW +: DW] = 32'h00001C72;
    for (int i = 5; i <= 8; i++) w[i*DW +: DW] = 32'h0000071C;
    fill_mem(w, 32'h00010000, 32'h0, 32'h0);
    clear_log();
    pulse_start();
    wait_done(GRID*PER + 100, "uniform_done_timeout");
    repeat (3) @(negedge Clk);
    verify_sweep("uniform");
    chk("uniform_done_cycle", 32'(done_cyc - first_busy), 32'(GRID*PER));

    // table-driven cells in an otherwise empty lattice
    fill_mem('0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < NV; i++) begin
      fin_mem[vecs[i].addr] = pack_lanes(vecs[i].la, vecs[i].va, vecs[i].lb, vecs[i].vb);
      exp_p[vecs[i].addr]  = vecs[i].p;
      exp_ux[vecs[i].addr] = vecs[i].ux;
      exp_uy[vecs[i].addr] = vecs[i].uy;
    end
    clear_log();
    pulse_start();
    wait_done(GRID*PER + 100, "table_done_timeout");
    repeat (3) @(negedge Clk);
    for (int i = 0; i < NV; i++) begin
      k = vecs[i].addr;
      chk($sformatf("cell%0d_addr", k), {24'd0, log_addr[k]}, 32'(k));
      chk($sformatf("cell%0d_p", k), log_p[k], vecs[i].p);
      chk($sformatf("cell%0d_ux", k), log_ux[k], vecs[i].ux);
      chk($sformatf("cell%0d_uy", k), log_uy[k], vecs[i].uy);
      $display("cell %0d: p=%h ux=%h uy=%h", k, log_p[k], log_ux[k], log_uy[k]);
    end
    verify_sweep("table");

    // all-zero lattice: every cell takes the 4-cycle path
    fill_mem('0, 32'h0, 32'h0, 32'h0);
    clear_log();
    pulse_start();
    wait_done(GRID*4 + 100, "zero_done_timeout");
    repeat (3) @(negedge Clk);
    verify_sweep("zero");
    chk("zero_done_cycle", 32'(done_cyc - first_busy), 32'(GRID*4));

    // start held high across a whole sweep
    clear_log();
    @(negedge Clk) start = 1'b1;
    wait_done(GRID*4 + 100, "held_done_timeout");
    @(negedge Clk);
    @(negedge Clk);
    #1;
    chk("held_writes", 32'(wr_n), 32'(GRID));
    chk("held_done_pulses", 32'(done_cnt), 32'd1);
    chk("held_reaccept_busy", {31'd0, busy}, 32'd1);
    $display("held start: writes=%0d done=%0d busy=%0b", wr_n, done_cnt, busy);
    start = 1'b0;
    wait_done(GRID*4 + 100, "held_second_done_timeout");
    repeat (3) @(negedge Clk);

    // reset during DIV of cell 10
    fin_mem[10] = pack_lanes(1, 32'h00010000, -1, 32'h0);
    exp_p[10] = 32'h00010000; exp_ux[10] = 32'h00010000;
    clear_log();
    pulse_start();
    k = 0;
    while (wr_n < 10 && k < 200) begin
      @(negedge Clk);
      #1;
      k++;
    end
    chk("rst_reach_cell10", 32'(wr_n), 32'd10);
    repeat (6) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    chk("rst_busy_async", {31'd0, busy}, 32'd0);
    chk("rst_we_async", {29'd0, WE_p_mem, WE_ux_mem, WE_uy_mem}, 32'd0);
    repeat (5) @(negedge Clk);
    hits = 0;
    for (int i = 0; i < wr_n && i < LOGN; i++) if (log_addr[i] == AW'(10)) hits++;
    chk("rst_no_write_10", 32'(hits), 32'd0);
    chk("rst_writes_before", 32'(wr_n), 32'd10);
    $display("mid-sweep reset: writes=%0d busy=%0b", wr_n, busy);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    clear_log();
    pulse_start();
    wait_done(GRID*4 + PER + 100, "rst_restart_done_timeout");
    repeat (3) @(negedge Clk);
    chk("rst_restart_first_addr", {24'd0, log_addr[0]}, 32'd0);
    verify_sweep("restart");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
